// File: rtl/clb_pkg.sv
// clb_pkg: shared state encoding and width/field helpers for the CLB
// configuration loader slice.
package clb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int DEF_NUM_LUTS     = 2;
  localparam int DEF_MUX_LEVEL    = 1;
  localparam int DEF_LUT_CFG_BITS = 16;

  // Total configuration word: all LUT tables plus the F-mux select field.
  function automatic int cfg_width(input int num_luts, input int lut_cfg_bits,
                                   input int mux_level);
    return num_luts * lut_cfg_bits + mux_level;
  endfunction

  // The mux field sits in the low bits of the word.
  function automatic int mux_lo();
    return 0;
  endfunction

  function automatic int mux_hi(input int mux_level);
    return mux_level - 1;
  endfunction

  // LUT k occupies the slice just above the mux field and the LUTs below it.
  function automatic int lut_lo(input int k, input int lut_cfg_bits,
                                input int mux_level);
    return mux_level + k * lut_cfg_bits;
  endfunction

  function automatic int lut_hi(input int k, input int lut_cfg_bits,
                                input int mux_level);
    return mux_level + (k + 1) * lut_cfg_bits - 1;
  endfunction

endpackage

// File: rtl/clb_config_loader_if.sv
// clb_config_loader_if: serial stream handshake plus committed configuration
// outputs. The master is the bitstream source, the slave is the loader.
interface clb_config_loader_if
  import clb_pkg::*;
#(
  parameter int CFG_WIDTH = cfg_width(DEF_NUM_LUTS, DEF_LUT_CFG_BITS, DEF_MUX_LEVEL),
  parameter int MUX_LEVEL = DEF_MUX_LEVEL
);
  logic                 start;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 bit_ready;
  logic [CFG_WIDTH-1:0] config_out;
  logic [MUX_LEVEL-1:0] mux_cfg;
  logic                 cen;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, bit_in, bit_valid,
    input  bit_ready, config_out, mux_cfg, cen, busy, done, err
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output bit_ready, config_out, mux_cfg, cen, busy, done, err
  );
endinterface

// File: rtl/clb_cfg_shifter.sv
// clb_cfg_shifter: shadow shift register, accepted-bit counter and (when
// CLB_CFG_PARITY_EN is defined) the running parity of the shifted data.
module clb_cfg_shifter
  import clb_pkg::*;
#(
  parameter int CFG_WIDTH = 33,
  parameter int CNT_W     = $clog2(CFG_WIDTH + 1)
) (
  input  logic                 cclk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [CFG_WIDTH-1:0] shadow,
  output logic [CFG_WIDTH-1:0] shadow_next,
  output logic [CNT_W-1:0]     count
`ifdef CLB_CFG_PARITY_EN
  ,
  output logic                 parity
`endif
);

  // First bit sent migrates to the MSB; the word after this accept is exposed
  // so the commit can capture it on the same edge as the last bit.
  assign shadow_next = {shadow[CFG_WIDTH-2:0], bit_in};

  // Shadow word and bit count advance together, only on accepted data bits.
  always_ff @(posedge cclk) begin
    if (rst || clear) begin
      shadow <= '0;
      count  <= '0;
    end else if (shift_en) begin
      shadow <= shadow_next;
      count  <= count + CNT_W'(1);
    end
  end

`ifdef CLB_CFG_PARITY_EN
  // Running XOR of every data bit shifted in, equal to ^shadow at all times.
  always_ff @(posedge cclk) begin
    if (rst || clear) begin
      parity <= 1'b0;
    end else if (shift_en) begin
      parity <= parity ^ bit_in;
    end
  end
`endif

endmodule

// File: rtl/clb_config_loader.sv
// clb_config_loader: bit-serial CLB configuration loader. Assembles a word in
// a shadow register and commits it atomically with a one-cycle cen strobe.
// Optional feature macro: CLB_CFG_PARITY_EN (trailing even-parity bit check).
module clb_config_loader
  import clb_pkg::*;
#(
  parameter int NUM_LUTS     = DEF_NUM_LUTS,
  parameter int MUX_LEVEL    = DEF_MUX_LEVEL,
  parameter int LUT_CFG_BITS = DEF_LUT_CFG_BITS
) (
  input logic                cclk,
  input logic                rst,
  clb_config_loader_if.slave cfg
);

  localparam int CFG_WIDTH = cfg_width(NUM_LUTS, LUT_CFG_BITS, MUX_LEVEL);
  localparam int CNT_W     = $clog2(CFG_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_WIDTH - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic                   bit_ready;
  logic                   busy;
  logic                   accept;
  logic                   clear;
  logic                   shift_en;
  logic                   last_data;
  logic                   commit_load;
  logic [CFG_WIDTH-1:0]   shadow;
  logic [CFG_WIDTH-1:0]   shadow_next;
  logic [CFG_WIDTH-1:0]   commit_word;
  logic [CFG_WIDTH-1:0]   config_q;
  logic [CNT_W-1:0]       count;
  logic                   cen_q;
  logic                   done_q;
`ifdef CLB_CFG_PARITY_EN
  logic                   parity;
  logic                   parity_accept;
  logic                   parity_ok;
  logic                   err_q;
`endif

  // A start outside COMMIT always wipes the partial word; a bit presented
  // alongside it is discarded rather than shifted.
  assign accept      = cfg.bit_valid && bit_ready;
  assign clear       = cfg.start && (state_q != COMMIT);
  assign shift_en    = accept && (state_q == SHIFT) && !cfg.start;
  assign last_data   = shift_en && (count == LAST_IDX);
  assign commit_load = (state_d == COMMIT) && (state_q != COMMIT);
  assign commit_word = (state_q == SHIFT) ? shadow_next : shadow;

`ifdef CLB_CFG_PARITY_EN
  assign parity_accept = accept && (state_q == PARITY) && !cfg.start;
  assign parity_ok     = ~(parity ^ cfg.bit_in);
`endif

  clb_cfg_shifter #(
    .CFG_WIDTH (CFG_WIDTH),
    .CNT_W     (CNT_W)
  ) u_shifter (
    .cclk        (cclk),
    .rst         (rst),
    .clear       (clear),
    .shift_en    (shift_en),
    .bit_in      (cfg.bit_in),
    .shadow      (shadow),
    .shadow_next (shadow_next),
    .count       (count)
`ifdef CLB_CFG_PARITY_EN
    ,
    .parity      (parity)
`endif
  );

  // State register.
  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: restart from SHIFT/PARITY, single-cycle COMMIT back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg.start) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_data) begin
`ifdef CLB_CFG_PARITY_EN
          state_d = PARITY;
`else
          state_d = COMMIT;
`endif
        end
      end
      PARITY: begin
`ifdef CLB_CFG_PARITY_EN
        if (cfg.start) begin
          state_d = SHIFT;
        end else if (parity_accept) begin
          state_d = parity_ok ? COMMIT : IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Unregistered outputs decoded from the current state.
  always_comb begin
    bit_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      SHIFT, PARITY: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        bit_ready = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Commit word, cen strobe and sticky done; cen lasts exactly the COMMIT cycle.
  always_ff @(posedge cclk) begin
    if (rst) begin
      config_q <= '0;
      cen_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cen_q <= commit_load;
      if (commit_load) config_q <= commit_word;
      if (state_q == IDLE && cfg.start) begin
        done_q <= 1'b0;
      end else if (state_q == COMMIT) begin
        done_q <= 1'b1;
      end
    end
  end

`ifdef CLB_CFG_PARITY_EN
  // Sticky parity error, cleared when a fresh load starts from IDLE.
  always_ff @(posedge cclk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && cfg.start) begin
      err_q <= 1'b0;
    end else if (parity_accept && !parity_ok) begin
      err_q <= 1'b1;
    end
  end
  assign cfg.err = err_q;
`else
  assign cfg.err = 1'b0;
`endif

  assign cfg.bit_ready  = bit_ready;
  assign cfg.busy       = busy;
  assign cfg.config_out = config_q;
  assign cfg.mux_cfg    = config_q[MUX_LEVEL-1:0];
  assign cfg.cen        = cen_q;
  assign cfg.done       = done_q;

endmodule

// File: tb/tb_clb_config_loader.sv
// tb_clb_config_loader: directed and randomized loads checked against a
// bit-position model of the expected configuration word.
module tb_clb_config_loader;

  localparam int NUM_LUTS     = 2;
  localparam int MUX_LEVEL    = 1;
  localparam int LUT_CFG_BITS = 16;
  localparam int W            = NUM_LUTS * LUT_CFG_BITS + MUX_LEVEL;

  logic cclk = 1'b0;
  logic rst  = 1'b0;

  clb_config_loader_if #(.CFG_WIDTH(W), .MUX_LEVEL(MUX_LEVEL)) cfg ();

  clb_config_loader #(
    .NUM_LUTS     (NUM_LUTS),
    .MUX_LEVEL    (MUX_LEVEL),
    .LUT_CFG_BITS (LUT_CFG_BITS)
  ) dut (
    .cclk (cclk),
    .rst  (rst),
    .cfg  (cfg)
  );

  always #5 cclk = ~cclk;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  // Reference model state: last committed word, sticky flags, bits accepted.
  logic [W-1:0] model_cfg  = '0;
  logic         model_done = 1'b0;
  logic         model_err  = 1'b0;
  logic         sent[$];
  logic [63:0]  rnd;

  int   cen_count  = 0;
  int   cen_double = 0;
  logic cen_prev   = 1'b0;

  // Count cen pulses and back-to-back highs, sampled mid-cycle.
  always @(negedge cclk) begin
    if (cfg.cen === 1'b1) begin
      cen_count <= cen_count + 1;
      if (cen_prev) cen_double <= cen_double + 1;
    end
    cen_prev <= (cfg.cen === 1'b1);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // The i-th bit accepted since the last clear lands at position W-1-i.
  function automatic logic [W-1:0] packBits();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < sent.size(); i++) begin
      if (sent[i]) w[W-1-i] = 1'b1;
    end
    return w;
  endfunction

  task automatic sendBit(input logic b, input int gap);
    int idle;
    int guard;
    idle = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    cfg.bit_valid = 1'b0;
    repeat (idle) tick();
    guard = 0;
    while (cfg.bit_ready !== 1'b1 && guard < 8) begin
      tick();
      guard++;
    end
    if (guard == 8) begin
      checks_total++;
      checks_failed++;
      $display("[TB] FAIL ready_timeout: bit_ready=%b, expected 1", cfg.bit_ready);
    end
    cfg.bit_valid = 1'b1;
    cfg.bit_in    = b;
    tick();
    cfg.bit_valid = 1'b0;
    sent.push_back(b);
  endtask

  // One full load: optional junk prefix + restart, optional reset abort,
  // optional bad parity bit, optional start pulse during COMMIT.
  task automatic applyStimulus(input logic [W-1:0] word, input int gap,
                               input int restart_at, input int reset_at,
                               input bit bad_parity, input bit start_in_commit);
    int           base_cen;
    logic [W-1:0] expect_word;
    logic         p;
    base_cen = cen_count;
    cfg.start = 1'b1;
    tick();
    cfg.start = 1'b0;
    sent.delete();
    model_done = 1'b0;
    model_err  = 1'b0;
    checkOutput("busy_after_start", cfg.busy, 1);
    checkOutput("done_cleared", cfg.done, model_done);
    if (restart_at >= 0) begin
      for (int i = 0; i < restart_at; i++) sendBit(1'($urandom_range(0, 1)), gap);
      cfg.start     = 1'b1;
      cfg.bit_valid = 1'b1;
      cfg.bit_in    = 1'($urandom_range(0, 1));
      tick();
      cfg.start     = 1'b0;
      cfg.bit_valid = 1'b0;
      sent.delete();
      checkOutput("restart_busy", cfg.busy, 1);
    end
    for (int i = 0; i < W; i++) begin
      if (i == reset_at) begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sent.delete();
        model_cfg  = '0;
        model_done = 1'b0;
        model_err  = 1'b0;
        checkOutput("rst_mid_cfg", cfg.config_out, model_cfg);
        checkOutput("rst_mid_busy", cfg.busy, 0);
        checkOutput("rst_mid_done", cfg.done, model_done);
        checkOutput("rst_mid_no_cen", cen_count - base_cen, 0);
        return;
      end
      sendBit(word[W-1-i], gap);
    end
    expect_word = packBits();
    p = (^expect_word) ^ bad_parity;
`ifdef CLB_CFG_PARITY_EN
    checkOutput("parity_wait_cen", cfg.cen, 0);
    checkOutput("parity_ready", cfg.bit_ready, 1);
    cfg.bit_valid = 1'b1;
    cfg.bit_in    = p;
    tick();
    cfg.bit_valid = 1'b0;
    if (bad_parity) begin
      model_err = 1'b1;
      checkOutput("par_err", cfg.err, model_err);
      checkOutput("par_cfg_kept", cfg.config_out, model_cfg);
      checkOutput("par_no_cen", cfg.cen, 0);
      checkOutput("par_busy", cfg.busy, 0);
      checkOutput("par_done", cfg.done, model_done);
      tick();
      checkOutput("par_cen_total", cen_count - base_cen, 0);
      return;
    end
`else
    if (bad_parity && p !== ^expect_word) $display("[TB] parity bit not sent in this build");
`endif
    model_cfg = expect_word;
    checkOutput("commit_cen", cfg.cen, 1);
    checkOutput("commit_word", cfg.config_out, model_cfg);
    checkOutput("commit_mux", cfg.mux_cfg, model_cfg[MUX_LEVEL-1:0]);
    checkOutput("commit_done_low", cfg.done, 0);
    checkOutput("commit_busy", cfg.busy, 0);
    if (start_in_commit) cfg.start = 1'b1;
    tick();
    cfg.start  = 1'b0;
    model_done = 1'b1;
    checkOutput("post_cen", cfg.cen, 0);
    checkOutput("post_done", cfg.done, model_done);
    checkOutput("post_err", cfg.err, model_err);
    checkOutput("post_busy", cfg.busy, 0);
    checkOutput("post_word", cfg.config_out, model_cfg);
    checkOutput("cen_pulses", cen_count - base_cen, 1);
  endtask

  initial begin
    cfg.start     = 1'b0;
    cfg.bit_in    = 1'b0;
    cfg.bit_valid = 1'b0;

    $display("[TB] reset");
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_config", cfg.config_out, 0);
    checkOutput("rst_mux", cfg.mux_cfg, 0);
    checkOutput("rst_cen", cfg.cen, 0);
    checkOutput("rst_busy", cfg.busy, 0);
    checkOutput("rst_done", cfg.done, 0);
    checkOutput("rst_err", cfg.err, 0);
    checkOutput("rst_ready", cfg.bit_ready, 0);

    $display("[TB] basic load");
    applyStimulus(33'h1_0000_0001, 0, -1, -1, 1'b0, 1'b0);
    checkOutput("basic_mux", cfg.mux_cfg, 1);

    $display("[TB] throttled load");
    applyStimulus(33'h1_0000_0001, 2, -1, -1, 1'b0, 1'b0);

    $display("[TB] restart after 10 bits");
    applyStimulus({W{1'b1}}, 0, 10, -1, 1'b0, 1'b0);

    $display("[TB] reset mid-shift then full load");
    rnd = {$urandom(), $urandom()};
    applyStimulus(rnd[W-1:0], 0, -1, 20, 1'b0, 1'b0);
    rnd = {$urandom(), $urandom()};
    applyStimulus(rnd[W-1:0], -1, -1, -1, 1'b0, 1'b0);

    $display("[TB] start during commit is ignored");
    rnd = {$urandom(), $urandom()};
    applyStimulus(rnd[W-1:0], 0, -1, -1, 1'b0, 1'b1);

    $display("[TB] parity good then bad");
    applyStimulus({W{1'b1}}, 0, -1, -1, 1'b0, 1'b0);
    applyStimulus({W{1'b1}}, 0, -1, -1, 1'b1, 1'b0);

    $display("[TB] randomized loads");
    for (int n = 0; n < 10; n++) begin
      int rs;
      int rr;
      rnd = {$urandom(), $urandom()};
      rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : -1;
      rr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W - 1)) : -1;
      applyStimulus(rnd[W-1:0], -1, rs, rr, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end

    tick();
    checkOutput("cen_never_double", cen_double, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
